// File: rtl/y_sig_compactor.sv
// Folds the y bus into a MISR signature over NUM_VECTORS capture cycles and compares it to a golden word.
// Optional macro Y_SIG_XDETECT_EN adds a simulation-only sticky X/Z detector on y.
module y_sig_compactor #(
   parameter int                   Y_WIDTH     = 319,
   parameter int                   SIG_WIDTH   = 32,
   parameter int                   NUM_VECTORS = 21,
   parameter logic [SIG_WIDTH-1:0] POLY        = 32'h04C11DB7,
   parameter logic [SIG_WIDTH-1:0] SEED        = 32'hFFFFFFFF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [Y_WIDTH-1:0]   y,
   input  logic [SIG_WIDTH-1:0] expected_sig,
   output logic                 busy,
   output logic [SIG_WIDTH-1:0] sig,
   output logic                 sig_valid,
   output logic                 match,
   output logic [15:0]          sample_count,
   output logic                 x_seen
);

   // state | meaning
   // IDLE  | waiting for start, outputs hold
   // RUN   | folding one y sample per cycle into the MISR
   // DONE  | signature final, sig_valid high, match latched

   localparam int         N_WORDS = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
   localparam int         W       = N_WORDS * SIG_WIDTH;
   localparam logic [15:0] NV     = 16'(NUM_VECTORS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state;
   logic [W-1:0]         y_ext;
   logic [SIG_WIDTH-1:0] fold;
   logic [SIG_WIDTH-1:0] misr_next;
   logic [15:0]          count_next;
   logic                 x_now;
   logic                 run_x_q;
   logic                 run_x_any;

   always_comb begin
      y_ext                = '0;
      y_ext[Y_WIDTH-1:0]   = y;
      fold                 = '0;
      for (int w = 0; w < N_WORDS; w++) begin
         fold = fold ^ y_ext[w*SIG_WIDTH +: SIG_WIDTH];
      end
      misr_next  = {sig[SIG_WIDTH-2:0], 1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : '0) ^ fold;
      count_next = sample_count + 16'd1;
   end

`ifdef Y_SIG_XDETECT_EN
   logic x_seen_q;

   // Four-state compare: only meaningful in simulation, never synthesised.
   always_comb x_now = ((^y) === 1'bx);

   always_ff @(posedge clk) begin
      if (rst) begin
         x_seen_q <= 1'b0;
         run_x_q  <= 1'b0;
      end else if (start) begin
         run_x_q  <= 1'b0;
      end else if (state == RUN && x_now) begin
         x_seen_q <= 1'b1;
         run_x_q  <= 1'b1;
      end
   end

   assign x_seen = x_seen_q;
`else
   assign x_now   = 1'b0;
   assign run_x_q = 1'b0;
   assign x_seen  = 1'b0;
`endif

   assign run_x_any = run_x_q | x_now;

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         sig          <= SEED;
         sample_count <= '0;
         busy         <= 1'b0;
         sig_valid    <= 1'b0;
         match        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  sig          <= SEED;
                  sample_count <= '0;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            RUN: begin
               // A start here restarts the run; the y of this cycle is discarded.
               if (start) begin
                  sig          <= SEED;
                  sample_count <= '0;
               end else begin
                  sig          <= misr_next;
                  sample_count <= count_next;
                  if (count_next == NV) begin
                     state     <= DONE;
                     busy      <= 1'b0;
                     sig_valid <= 1'b1;
                     match     <= (misr_next == expected_sig) && !run_x_any;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  sig          <= SEED;
                  sample_count <= '0;
                  sig_valid    <= 1'b0;
                  match        <= 1'b0;
                  busy         <= 1'b1;
                  state        <= RUN;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_y_sig_compactor.sv
// Directed bench for y_sig_compactor: one instance with NUM_VECTORS=1, one with the default 21.
module tb_y_sig_compactor;

   localparam logic [31:0] POLY = 32'h04C11DB7;

   logic         clk = 1'b0;
   logic         rst;
   logic         start1, start21;
   logic [318:0] y1, y21;
   logic [31:0]  exp1, exp21;

   logic         busy1, sv1, match1, xs1;
   logic [31:0]  sig1;
   logic [15:0]  cnt1;
   logic         busy21, sv21, match21, xs21;
   logic [31:0]  sig21;
   logic [15:0]  cnt21;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   y_sig_compactor #(.NUM_VECTORS(1)) d1 (
      .clk(clk), .rst(rst), .start(start1), .y(y1), .expected_sig(exp1),
      .busy(busy1), .sig(sig1), .sig_valid(sv1), .match(match1),
      .sample_count(cnt1), .x_seen(xs1)
   );

   y_sig_compactor #(.NUM_VECTORS(21)) d21 (
      .clk(clk), .rst(rst), .start(start21), .y(y21), .expected_sig(exp21),
      .busy(busy21), .sig(sig21), .sig_valid(sv21), .match(match21),
      .sample_count(cnt21), .x_seen(xs21)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Bit-serial fold and MISR step, independent of word slicing.
   function automatic logic [31:0] fold_m(input logic [318:0] v);
      logic [31:0] f = '0;
      for (int i = 0; i < 319; i++) f[i % 32] = f[i % 32] ^ v[i];
      return f;
   endfunction

   function automatic logic [31:0] step_m(input logic [31:0] s, input logic [318:0] v);
      logic msb = s[31];
      s = s << 1;
      if (msb) s = s ^ POLY;
      return s ^ fold_m(v);
   endfunction

   function automatic logic [318:0] pat(input int k);
      logic [318:0] p = '0;
      p[31:0]          = 32'h9E3779B9 * 32'(k + 1);
      p[300 + (k % 10)] = 1'b1;
      p[k * 7]          = ~p[k * 7];
      return p;
   endfunction

   initial begin
      logic [31:0] model;

      rst = 1'b1; start1 = 0; start21 = 0; y1 = '0; y21 = '0;
      exp1 = 32'hFB3EE249; exp21 = '0;

      // Case 1: reset then idle
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      chk("rst_sig",   64'(sig1), 64'hFFFFFFFF);
      chk("rst_busy",  64'(busy1), 64'd0);
      chk("rst_valid", 64'(sv1), 64'd0);
      chk("rst_match", 64'(match1), 64'd0);
      chk("rst_cnt",   64'(cnt1), 64'd0);
      chk("rst_xseen", 64'(xs1), 64'd0);

      // Case 2: y=0, single sample
      start1 = 1; tick(); start1 = 0; y1 = '0;
      chk("c2_busy",  64'(busy1), 64'd1);
      chk("c2_valid0",64'(sv1), 64'd0);
      tick();
      chk("c2_sig",   64'(sig1), 64'hFB3EE249);
      chk("c2_valid", 64'(sv1), 64'd1);
      chk("c2_cnt",   64'(cnt1), 64'd1);
      chk("c2_match", 64'(match1), 64'd1);
      chk("c2_busy0", 64'(busy1), 64'd0);
      tick();
      chk("c2_hold",  64'(sig1), 64'hFB3EE249);

      // Case 3: fold behaviour
      start1 = 1; tick(); start1 = 0; y1 = '0; y1[0] = 1'b1; tick();
      chk("c3_y0",     64'(sig1), 64'hFB3EE248);
      chk("c3_nomatch",64'(match1), 64'd0);
      start1 = 1; tick(); start1 = 0; y1 = '0; y1[32] = 1'b1; tick();
      chk("c3_y32",    64'(sig1), 64'hFB3EE248);
      start1 = 1; tick(); start1 = 0; y1 = '0; y1[0] = 1'b1; y1[32] = 1'b1; tick();
      chk("c3_cancel", 64'(sig1), 64'hFB3EE249);
      start1 = 1; tick(); start1 = 0; y1 = '0; y1[318] = 1'b1; tick();
      chk("c3_top",    64'(sig1), 64'(32'hFB3EE249 ^ 32'h40000000));

      // Case 4: restart mid-run on the 21-sample instance
      model = 32'hFFFFFFFF;
      for (int k = 0; k < 21; k++) model = step_m(model, pat(k));
      exp21 = model;
      start21 = 1; tick(); start21 = 0;
      for (int k = 0; k < 10; k++) begin
         y21 = pat(k + 3); tick();
      end
      chk("c4_cnt10", 64'(cnt21), 64'd10);
      start21 = 1; y21 = pat(99); tick(); start21 = 0;
      chk("c4_rcnt",  64'(cnt21), 64'd0);
      chk("c4_rsig",  64'(sig21), 64'hFFFFFFFF);
      chk("c4_rbusy", 64'(busy21), 64'd1);
      for (int k = 0; k < 20; k++) begin
         y21 = pat(k); tick();
      end
      chk("c4_valid20", 64'(sv21), 64'd0);
      y21 = pat(20); tick();
      chk("c4_valid21", 64'(sv21), 64'd1);
      chk("c4_cnt",     64'(cnt21), 64'd21);
      chk("c4_sig",     64'(sig21), 64'(model));
      chk("c4_match",   64'(match21), 64'd1);
      chk("c4_busy",    64'(busy21), 64'd0);

      // Case 5: rst together with start in RUN
      start21 = 1; tick(); start21 = 0;
      for (int k = 0; k < 5; k++) begin
         y21 = pat(k); tick();
      end
      chk("c5_cnt5", 64'(cnt21), 64'd5);
      rst = 1; start21 = 1; tick(); rst = 0; start21 = 0;
      chk("c5_busy",  64'(busy21), 64'd0);
      chk("c5_sig",   64'(sig21), 64'hFFFFFFFF);
      chk("c5_cnt",   64'(cnt21), 64'd0);
      chk("c5_valid", 64'(sv21), 64'd0);
      tick(); tick();
      chk("c5_idle",  64'(busy21), 64'd0);
      chk("c5_idsig", 64'(sig21), 64'hFFFFFFFF);

`ifdef Y_SIG_XDETECT_EN
      // Case 6: X on y[7] for one RUN cycle
      exp1 = 32'hFB3EE249;
      start1 = 1; tick(); start1 = 0; y1 = '0; y1[7] = 1'bx; tick();
      y1 = '0;
      chk("c6_xseen",  64'(xs1), 64'd1);
      chk("c6_match",  64'(match1), 64'd0);
      start1 = 1; tick(); start1 = 0;
      chk("c6_xstart", 64'(xs1), 64'd1);
      tick();
      chk("c6_xdone",  64'(xs1), 64'd1);
`else
      chk("nox_xseen", 64'(xs21), 64'd0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/y_sig_compactor.md
Name: y_sig_compactor

Overview:
- Downstream consumer of the fuzz DUT output bus `y`. It replaces per-cycle `$strobe` dumps with a compact signature.
- Each capture cycle it samples `y` on the rising clock edge, XOR-folds it to SIG_WIDTH bits and clocks it into a MISR.
- After NUM_VECTORS samples it presents a final signature and compares it against an expected value.
- Used to cross-check synthesised and reference netlists across simulators with a single word compare.

Parameters:
- Y_WIDTH, 319, width of the DUT output bus y.
- SIG_WIDTH, 32, MISR/signature width.
- NUM_VECTORS, 21, number of y samples folded per run (1..2^16-1).
- POLY, 32'h04C11DB7, MISR feedback polynomial (SIG_WIDTH bits).
- SEED, 32'hFFFFFFFF, MISR value loaded on start.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, one-cycle pulse that begins (or restarts) a capture run.
- y, input, Y_WIDTH, DUT output bus, sampled every RUN cycle.
- expected_sig, input, SIG_WIDTH, golden signature; sampled when DONE is entered.
- busy, output, 1, high while in RUN.
- sig, output, SIG_WIDTH, current MISR value.
- sig_valid, output, 1, high in DONE.
- match, output, 1, valid in DONE; 1 when sig == expected_sig.
- sample_count, output, 16, number of samples folded so far in this run.
- x_seen, output, 1, sticky X/Z flag (see Optional Feature).

Behaviour:
- Reset (rst=1 at a clk edge; overrides all other inputs):
  - state=IDLE, sig=SEED, sample_count=0.
  - busy=0, sig_valid=0, match=0, x_seen=0.
- Fold:
  - y is zero-extended to W = ceil(Y_WIDTH/SIG_WIDTH)*SIG_WIDTH bits (320 at defaults, giving 10 words).
  - fold = XOR of all SIG_WIDTH-bit words; word 0 = y[SIG_WIDTH-1:0].
- MISR step:
  - next = {sig[SIG_WIDTH-2:0],1'b0} ^ (sig[SIG_WIDTH-1] ? POLY : 0) ^ fold.
- States:
  - IDLE:
    - Outputs hold.
    - start=1 -> sig=SEED, sample_count=0, go to RUN. The start cycle itself does not sample y.
  - RUN:
    - busy=1.
    - Each cycle: sig=next, sample_count+=1.
    - When the incremented count equals NUM_VECTORS: go to DONE in the same edge, latch match = (next == expected_sig).
  - DONE:
    - sig_valid=1; sig, match and sample_count hold.
    - start=1 -> reload SEED, clear sample_count/sig_valid/match, go to RUN.
- start while in RUN: restart the run.
  - sig=SEED, sample_count=0, stay in RUN.
  - The y present in that cycle is not sampled.
- Latency:
  - The first sample is taken 1 cycle after start.
  - sig_valid rises on the edge that folds the NUM_VECTORS-th sample, i.e. NUM_VECTORS cycles after the start edge.
- sample_count never wraps; NUM_VECTORS is bounded by its width.
- x_seen is cleared only by rst, never by start.

Optional Feature:
- Macro: Y_SIG_XDETECT_EN.
- With the macro defined:
  - Each RUN cycle, if (^y) === 1'bx, x_seen sets and stays set until rst.
  - The MISR still updates. Its value is then unspecified, and match is forced to 0 for that run.
  - This check is simulation-only and is not synthesised.
- Without the macro: x_seen is tied to 0 and match behaves as normal.

Test Plan:
- All cases below use NUM_VECTORS=1 unless stated.
- Case 1: rst for 2 cycles, then idle 3 cycles -> sig=FFFFFFFF, busy=0, sig_valid=0, match=0, sample_count=0.
- Case 2: start, with y=0 on the next cycle -> sig=FB3EE249, sig_valid=1, sample_count=1. With expected_sig=FB3EE249, match=1.
- Case 3: start with y=1 -> sig=FB3EE248. With y[32]=1 only, sig is also FB3EE248. With y[0] and y[32] both set, the bits cancel and sig=FB3EE249.
- Case 4: NUM_VECTORS=21, start, then start again at sample 10 ->
  - sample_count returns to 0 and sig to FFFFFFFF.
  - sig_valid rises exactly 21 cycles after the second start.
  - The result equals a clean 21-sample run.
- Case 5: assert rst in RUN at sample 5, together with start -> next state IDLE, sig=FFFFFFFF, busy=0, no run begins.
- Case 6 (Y_SIG_XDETECT_EN defined): drive y[7]=1'bx for one RUN cycle -> x_seen=1 and remains 1 through DONE and a new start. match=0 even when expected_sig equals sig.
